// File: rtl/ps2_scancode_framer.sv
// PS/2 device-to-host receiver: synchronise and deglitch the lines, frame 11-bit words, fold E0/F0 prefixes.
// Optional PS2_PARITY_CHECK_EN enforces odd parity; otherwise the parity bit is sampled and ignored.

module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt
);

  logic       sync1;
  logic       sync2;
  logic [7:0] cnt;

  // The filtered level flips only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      filt  <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 != filt) begin
        if (cnt == 8'(FILTER_LEN - 1)) begin
          filt <= sync2;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

module ps2_scancode_framer #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic       scan_received,
  output logic [7:0] scan,
  output logic       extended,
  output logic       released,
  output logic       frame_error
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic            fclk;
  logic            fdata;
  logic            fclk_d;
  logic            fall;
  state_t          state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic [WD_W-1:0] wdog;
  logic            byte_valid;
  logic            frame_bad;
  logic            wd_abort;
  logic            ext_pend;
  logic            rel_pend;
`ifdef PS2_PARITY_CHECK_EN
  logic            par;
`endif

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (ps2clk),
    .filt (fclk)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (ps2data),
    .filt (fdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fclk_d <= 1'b1;
      fall   <= 1'b0;
    end else begin
      fclk_d <= fclk;
      fall   <= fclk_d & ~fclk;
    end
  end

  // Framer and watchdog; a fall in the expiry cycle takes priority and clears the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      wdog       <= '0;
      byte_valid <= 1'b0;
      frame_bad  <= 1'b0;
      wd_abort   <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par        <= 1'b0;
`endif
    end else begin
      byte_valid <= 1'b0;
      frame_bad  <= 1'b0;
      wd_abort   <= 1'b0;
      if (fall) begin
        wdog <= '0;
        case (state)
          IDLE: begin
            if (!fdata) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg <= {fdata, shreg[7:1]};
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            par <= fdata;
`endif
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
`ifdef PS2_PARITY_CHECK_EN
            if (fdata && (^{shreg, par})) begin
`else
            if (fdata) begin
`endif
              byte_valid <= 1'b1;
            end else begin
              frame_bad <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state == IDLE) begin
        wdog <= '0;
      end else if (wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
        wdog     <= '0;
        state    <= IDLE;
        wd_abort <= 1'b1;
      end else begin
        wdog <= wdog + WD_W'(1);
      end
    end
  end

  // Byte decoder: shreg is stable while the framer idles after the stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_received <= 1'b0;
      scan          <= '0;
      extended      <= 1'b0;
      released      <= 1'b0;
      frame_error   <= 1'b0;
      ext_pend      <= 1'b0;
      rel_pend      <= 1'b0;
    end else begin
      scan_received <= 1'b0;
      frame_error   <= frame_bad | wd_abort;
      if (wd_abort) begin
        ext_pend <= 1'b0;
        rel_pend <= 1'b0;
      end else if (byte_valid) begin
        case (shreg)
          8'hE0: ext_pend <= 1'b1;
          8'hF0: rel_pend <= 1'b1;
          8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hE1: ;
          8'h00, 8'hFF: begin
            ext_pend <= 1'b0;
            rel_pend <= 1'b0;
          end
          default: begin
            scan          <= shreg;
            extended      <= ext_pend;
            released      <= rel_pend;
            scan_received <= 1'b1;
            ext_pend      <= 1'b0;
            rel_pend      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_framer.sv
// Directed bench for ps2_scancode_framer: byte table plus latency, watchdog, glitch and reset sequences.

module tb_ps2_scancode_framer;

  localparam int unsigned FL   = 8;
  localparam int unsigned T    = 300;
  localparam int unsigned HALF = 40;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2clk;
  logic       ps2data;
  logic       scan_received;
  logic [7:0] scan;
  logic       extended;
  logic       released;
  logic       frame_error;

  int          checks = 0;
  int          errors = 0;
  int          sr_count = 0;
  int          fe_count = 0;
  int unsigned cyc = 0;
  int unsigned last_fall = 0;

  always #5 clk = ~clk;

  ps2_scancode_framer #(
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ps2clk       (ps2clk),
    .ps2data      (ps2data),
    .scan_received(scan_received),
    .scan         (scan),
    .extended     (extended),
    .released     (released),
    .frame_error  (frame_error)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (scan_received === 1'b1 || frame_error === 1'b1)) begin
      checks++;
      if (scan_received === 1'b1 && frame_error === 1'b1) begin
        errors++;
        $display("FAIL mutex actual=both_high expected=exclusive at cycle %0d", cyc);
      end
      if (scan_received === 1'b1) sr_count++;
      if (frame_error === 1'b1) fe_count++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mkframe(input logic [7:0] b, input bit flip, input bit bad_stop);
    return {~bad_stop, (~^b) ^ flip, b, 1'b0};
  endfunction

  // Each bit: data set while clock high, clock low for HALF, high for HALF.
  task automatic send_bits(input logic [10:0] frame, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      ps2data = frame[i];
      wait_cyc(4);
      if (glitch && (i == 3 || i == 7)) begin
        ps2clk = 1'b0;
        wait_cyc(FL - 1);
        ps2clk = 1'b1;
      end else begin
        wait_cyc(FL - 1);
      end
      wait_cyc(9);
      ps2clk    = 1'b0;
      last_fall = cyc;
      wait_cyc(HALF);
      ps2clk = 1'b1;
      wait_cyc(HALF / 2);
    end
    ps2data = 1'b1;
  endtask

  typedef struct {
    logic [7:0] b;
    bit         flip;
    bit         bad_stop;
    int         exp_sr;
    int         exp_fe;
    logic [7:0] exp_scan;
    bit         exp_ext;
    bit         exp_rel;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] b, input bit flip, input bit bad_stop,
                              input int sr, input int fe, input logic [7:0] s,
                              input bit e, input bit r);
    vec_t v;
    v.b = b; v.flip = flip; v.bad_stop = bad_stop;
    v.exp_sr = sr; v.exp_fe = fe; v.exp_scan = s; v.exp_ext = e; v.exp_rel = r;
    return v;
  endfunction

  vec_t vecs[21];

  initial begin
    int s0;
    int e0;
    int n;
    bit found;

    vecs[0]  = mk(8'h1C, 0, 0, 1, 0, 8'h1C, 0, 0);
    vecs[1]  = mk(8'hE0, 0, 0, 0, 0, 8'h1C, 0, 0);
    vecs[2]  = mk(8'hF0, 0, 0, 0, 0, 8'h1C, 0, 0);
    vecs[3]  = mk(8'h75, 0, 0, 1, 0, 8'h75, 1, 1);
    vecs[4]  = mk(8'h1C, 0, 0, 1, 0, 8'h1C, 0, 0);
    vecs[5]  = mk(8'hF0, 0, 0, 0, 0, 8'h1C, 0, 0);
    vecs[6]  = mk(8'hE0, 0, 0, 0, 0, 8'h1C, 0, 0);
    vecs[7]  = mk(8'h6B, 0, 0, 1, 0, 8'h6B, 1, 1);
    vecs[8]  = mk(8'hAA, 0, 0, 0, 0, 8'h6B, 1, 1);
    vecs[9]  = mk(8'hFA, 0, 0, 0, 0, 8'h6B, 1, 1);
    vecs[10] = mk(8'hE0, 0, 0, 0, 0, 8'h6B, 1, 1);
    vecs[11] = mk(8'hEE, 0, 0, 0, 0, 8'h6B, 1, 1);
    vecs[12] = mk(8'h74, 0, 0, 1, 0, 8'h74, 1, 0);
    vecs[13] = mk(8'hF0, 0, 0, 0, 0, 8'h74, 1, 0);
    vecs[14] = mk(8'h00, 0, 0, 0, 0, 8'h74, 1, 0);
    vecs[15] = mk(8'h5A, 0, 0, 1, 0, 8'h5A, 0, 0);
    vecs[16] = mk(8'hE0, 0, 0, 0, 0, 8'h5A, 0, 0);
    vecs[17] = mk(8'hFF, 0, 0, 0, 0, 8'h5A, 0, 0);
    vecs[18] = mk(8'h29, 0, 0, 1, 0, 8'h29, 0, 0);
    vecs[19] = mk(8'h1C, 0, 1, 0, 1, 8'h29, 0, 0);
`ifdef PS2_PARITY_CHECK_EN
    vecs[20] = mk(8'h1C, 1, 0, 0, 1, 8'h29, 0, 0);
`else
    vecs[20] = mk(8'h1C, 1, 0, 1, 0, 8'h1C, 0, 0);
`endif

    rst_n   = 1'b0;
    ps2clk  = 1'b1;
    ps2data = 1'b1;
    wait_cyc(5);
    check("rst_scan_received", scan_received, 0);
    check("rst_scan", scan, 8'h00);
    check("rst_extended", extended, 0);
    check("rst_released", released, 0);
    check("rst_frame_error", frame_error, 0);
    rst_n = 1'b1;
    wait_cyc(50);

    // Raw stop-bit falling edge to scan_received latency and pulse width.
    send_bits(mkframe(8'h1C, 0, 0), 10, 0);
    ps2data = 1'b1;
    wait_cyc(20);
    ps2clk = 1'b0;
    n = 0;
    found = 0;
    for (int k = 1; k <= 60 && !found; k++) begin
      wait_cyc(1);
      if (scan_received === 1'b1) begin
        found = 1;
        n = k;
      end
    end
    check("latency", n, FL + 5);
    check("lat_scan", scan, 8'h1C);
    check("lat_ext", extended, 0);
    check("lat_rel", released, 0);
    wait_cyc(1);
    check("pulse_width", scan_received, 0);
    wait_cyc(HALF);
    ps2clk = 1'b1;
    wait_cyc(60);

    for (int i = 0; i < 21; i++) begin
      s0 = sr_count;
      e0 = fe_count;
      send_bits(mkframe(vecs[i].b, vecs[i].flip, vecs[i].bad_stop), 11, 0);
      wait_cyc(40);
      check($sformatf("v%0d_pulses", i), sr_count - s0, vecs[i].exp_sr);
      check($sformatf("v%0d_errors", i), fe_count - e0, vecs[i].exp_fe);
      check($sformatf("v%0d_scan", i), scan, vecs[i].exp_scan);
      check($sformatf("v%0d_ext", i), extended, vecs[i].exp_ext);
      check($sformatf("v%0d_rel", i), released, vecs[i].exp_rel);
    end

    // Watchdog: E0, then a truncated frame, then silence.
    send_bits(mkframe(8'hE0, 0, 0), 11, 0);
    wait_cyc(40);
    s0 = sr_count;
    e0 = fe_count;
    send_bits(mkframe(8'h1C, 0, 0), 5, 0);
    found = 0;
    for (int k = 0; k < int'(T) + 200 && !found; k++) begin
      wait_cyc(1);
      if (fe_count != e0) found = 1;
    end
    check("wd_fired", found, 1);
    check("wd_not_early", (cyc - last_fall) >= T, 1);
    check("wd_not_late", (cyc - last_fall) <= T + FL + 12, 1);
    check("wd_no_pulse", sr_count - s0, 0);
    wait_cyc(40);
    s0 = sr_count;
    send_bits(mkframe(8'h1C, 0, 0), 11, 0);
    wait_cyc(40);
    check("wd_after_pulses", sr_count - s0, 1);
    check("wd_after_scan", scan, 8'h1C);
    check("wd_after_ext", extended, 0);

    // Clock glitches of FILTER_LEN-1 cycles inside a frame.
    s0 = sr_count;
    e0 = fe_count;
    send_bits(mkframe(8'h4B, 0, 0), 11, 1);
    wait_cyc(40);
    check("glitch_pulses", sr_count - s0, 1);
    check("glitch_errors", fe_count - e0, 0);
    check("glitch_scan", scan, 8'h4B);

    // Reset in the middle of a frame.
    send_bits(mkframe(8'hE0, 0, 0), 11, 0);
    send_bits(mkframe(8'h1C, 0, 0), 11, 0);
    wait_cyc(40);
    check("pre_rst_ext", extended, 1);
    s0 = sr_count;
    e0 = fe_count;
    send_bits(mkframe(8'h29, 0, 0), 5, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_scan", scan, 8'h00);
    check("arst_ext", extended, 0);
    check("arst_rel", released, 0);
    check("arst_sr", scan_received, 0);
    check("arst_fe", frame_error, 0);
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(40);
    send_bits(mkframe(8'h29, 0, 0), 11, 0);
    wait_cyc(40);
    check("post_rst_pulses", sr_count - s0, 1);
    check("post_rst_errors", fe_count - e0, 0);
    check("post_rst_scan", scan, 8'h29);
    check("post_rst_ext", extended, 0);
    check("post_rst_rel", released, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
